// File: rtl/pipe_ctrl_pkg.sv
// Shared bus widths, constants and FSM codes for the pipeline controller.
// Also provides the stall-request priority encoder.
package pipe_ctrl_pkg;

  localparam int StallW = 6;
  localparam int AddrW  = 32;

  typedef logic [StallW-1:0] stall_bus_t;
  typedef logic [AddrW-1:0]  inst_addr_t;

  localparam logic       Stop      = 1'b1;
  localparam logic       NoStop    = 1'b0;
  localparam logic       RstEnable = 1'b1;
  localparam inst_addr_t ZeroWord  = 32'h0000_0000;

  localparam stall_bus_t StallNone = 6'b000000;
  localparam stall_bus_t StallId   = 6'b000111;
  localparam stall_bus_t StallEx   = 6'b001111;
  localparam stall_bus_t StallMem  = 6'b011111;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Deepest requester wins: holding a later stage
  // must also hold everything upstream of it.
  function automatic stall_bus_t stall_encode(
    input logic id,
    input logic ex,
    input logic mem
  );
    stall_bus_t s;
    if (mem)
      s = StallMem;
    else if (ex)
      s = StallEx;
    else if (id)
      s = StallId;
    else
      s = StallNone;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles.
// Ports: clk, rst, stall_active, clear, limit -> expired.
module stall_watchdog (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_active,
  input  logic        clear,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count;
  logic [16:0] count_inc;

  assign count_inc = {1'b0, count} + 17'd1;

  always_ff @(posedge clk) begin
    if (rst || clear || !stall_active)
      count <= '0;
    else if (count != 16'hFFFF)
      count <= count + 16'd1;
  end

  // Fires on the cycle whose edge brings the count to the limit.
  assign expired = stall_active
                 && (count_inc >= {1'b0, limit});

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall encoding, exception redirect, stall watchdog.
// Ports: clk, rst, stallreq_{id,ex,mem}, excp_{req,vec,ack}, stall, flush, new_pc, stall_timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 255,
  parameter logic [31:0] TIMEOUT_VEC = 32'h0000_0040
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id,
  input  logic       stallreq_ex,
  input  logic       stallreq_mem,
  input  logic       excp_req,
  input  inst_addr_t excp_vec,
  output logic       excp_ack,
  output stall_bus_t stall,
  output logic       flush,
  output inst_addr_t new_pc,
  output logic       stall_timeout
);

  localparam logic [15:0] Limit = 16'(STALL_LIMIT);

  logic [1:0] state;
  logic [1:0] state_nx;
  inst_addr_t pend;
  logic       in_run;
  logic       in_flush;
  logic       take_excp;
  logic       take_to;
  logic       wd_active;
  logic       wd_clear;
  logic       wd_expired;

  assign in_run   = (state == ST_RUN);
  assign in_flush = (state == ST_FLUSH);

  always_comb begin
    stall = StallNone;
    if (rst != RstEnable && !in_flush)
      stall = stall_encode(stallreq_id, stallreq_ex, stallreq_mem);
  end

  assign take_excp = in_run && excp_req;
  assign take_to   = in_run && !excp_req && wd_expired;

  assign wd_active = (stall != StallNone);
  assign wd_clear  = in_flush || take_excp;

  stall_watchdog u_wd (
    .clk          (clk),
    .rst          (rst),
    .stall_active (wd_active),
    .clear        (wd_clear),
    .limit        (Limit),
    .expired      (wd_expired)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN: begin
        if (take_excp)
          state_nx = ST_PEND;
        else if (take_to)
          state_nx = ST_FLUSH;
      end
      ST_PEND: begin
        if (!stallreq_mem)
          state_nx = ST_FLUSH;
      end
      ST_FLUSH: state_nx = ST_RUN;
      default:  state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state         <= ST_RUN;
      pend          <= ZeroWord;
      excp_ack      <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      state    <= state_nx;
      excp_ack <= take_excp;
      if (take_excp)
        pend <= excp_vec;
      else if (take_to)
        pend <= TIMEOUT_VEC;
      if (take_to)
        stall_timeout <= 1'b1;
    end
  end

  assign flush  = in_flush;
  assign new_pc = in_flush ? pend : ZeroWord;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level reference model.
// Ports driven: all DUT inputs; DUT outputs compared every cycle.
module tb_pipe_ctrl;

  localparam int          LIM  = 8;
  localparam logic [31:0] TVEC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        excp_req = 1'b0;
  logic [31:0] excp_vec = 32'h0;
  logic        excp_ack;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pipe_ctrl #(
    .STALL_LIMIT (LIM),
    .TIMEOUT_VEC (TVEC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_req      (excp_req),
    .excp_vec      (excp_vec),
    .excp_ack      (excp_ack),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: exception in flight, flush cycle,
  // redirect target, stalled-cycle run length, watchdog flag.
  bit          m_ack = 0;
  bit          m_wait = 0;
  bit          m_fl = 0;
  logic [31:0] m_tgt = 32'h0;
  int          m_run = 0;
  bit          m_to = 0;

  function automatic logic [5:0] want_stall();
    if (rst || m_fl) return 6'b000000;
    if (stallreq_mem) return 6'b011111;
    if (stallreq_ex)  return 6'b001111;
    if (stallreq_id)  return 6'b000111;
    return 6'b000000;
  endfunction

  always @(posedge clk) begin
    logic [5:0] s;
    bit idle, take, fire, old_wait;
    if (rst) begin
      m_ack = 0; m_wait = 0; m_fl = 0;
      m_tgt = 32'h0; m_run = 0; m_to = 0;
    end else begin
      s = want_stall();
      idle = !m_wait && !m_fl;
      take = idle && excp_req;
      fire = idle && !excp_req && s != 0
             && (m_run + 1 >= LIM);
      old_wait = m_wait;
      if (s == 0 || m_fl || take) m_run = 0;
      else if (m_run < 65535) m_run = m_run + 1;
      m_ack = take;
      if (take) m_tgt = excp_vec;
      else if (fire) begin
        m_tgt = TVEC;
        m_to = 1;
      end
      m_fl   = fire || (old_wait && !stallreq_mem);
      m_wait = take || (old_wait && stallreq_mem);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", 32'(stall), 32'(want_stall()));
      chk("m_ack", 32'(excp_ack), 32'(m_ack));
      chk("m_flush", 32'(flush), 32'(m_fl));
      chk("m_new_pc", new_pc, m_fl ? m_tgt : 32'h0);
      chk("m_timeout", 32'(stall_timeout), 32'(m_to));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    stallreq_mem = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ack", 32'(excp_ack), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    cyc();
    rst = 1'b0;
    stallreq_mem = 1'b0;

    // ex stall for 3 cycles, then mem+id
    cyc();
    stallreq_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ex_stall", 32'(stall), 32'h0f);
      cyc();
    end
    stallreq_ex = 1'b0;
    @(negedge clk);
    chk("ex_release", 32'(stall), 32'h0);
    cyc();
    stallreq_mem = 1'b1;
    stallreq_id = 1'b1;
    @(negedge clk);
    chk("mem_id", 32'(stall), 32'h1f);
    cyc();
    stallreq_mem = 1'b0;
    stallreq_id = 1'b0;

    // exception in RUN
    cyc();
    excp_req = 1'b1;
    excp_vec = 32'h0000_0180;
    @(negedge clk);
    chk("b_ack0", 32'(excp_ack), 32'h0);
    cyc();
    @(negedge clk);
    chk("b_ack1", 32'(excp_ack), 32'h1);
    chk("b_noflush", 32'(flush), 32'h0);
    cyc();
    excp_req = 1'b0;
    @(negedge clk);
    chk("b_flush", 32'(flush), 32'h1);
    chk("b_new_pc", new_pc, 32'h0000_0180);
    chk("b_ack_low", 32'(excp_ack), 32'h0);
    cyc();
    @(negedge clk);
    chk("b_run_flush", 32'(flush), 32'h0);
    chk("b_run_pc", new_pc, 32'h0);

    // exception while memory stalls for 4 cycles
    cyc();
    stallreq_mem = 1'b1;
    excp_req = 1'b1;
    excp_vec = 32'h0000_0200;
    @(negedge clk);
    chk("c_stall", 32'(stall), 32'h1f);
    cyc();
    @(negedge clk);
    chk("c_ack", 32'(excp_ack), 32'h1);
    cyc();
    excp_req = 1'b0;
    cyc();
    @(negedge clk);
    chk("c_hold", 32'(flush), 32'h0);
    cyc();
    stallreq_mem = 1'b0;
    stallreq_ex = 1'b1;
    @(negedge clk);
    chk("c_fall", 32'(flush), 32'h0);
    cyc();
    @(negedge clk);
    chk("c_flush", 32'(flush), 32'h1);
    chk("c_new_pc", new_pc, 32'h0000_0200);
    chk("c_stall0", 32'(stall), 32'h0);
    cyc();
    stallreq_ex = 1'b0;

    // watchdog timeout after LIM stalled cycles
    cyc();
    stallreq_ex = 1'b1;
    repeat (LIM - 1) cyc();
    @(negedge clk);
    chk("d_pre", 32'(flush), 32'h0);
    chk("d_pre_to", 32'(stall_timeout), 32'h0);
    cyc();
    @(negedge clk);
    chk("d_flush", 32'(flush), 32'h1);
    chk("d_new_pc", new_pc, TVEC);
    chk("d_stall0", 32'(stall), 32'h0);
    chk("d_to", 32'(stall_timeout), 32'h1);
    chk("d_noack", 32'(excp_ack), 32'h0);
    cyc();
    @(negedge clk);
    chk("d_resume", 32'(stall), 32'h0f);
    cyc();
    stallreq_ex = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("d_sticky", 32'(stall_timeout), 32'h1);

    // exception on the timeout cycle wins
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    stallreq_ex = 1'b1;
    repeat (LIM - 1) cyc();
    excp_req = 1'b1;
    excp_vec = 32'h0000_0300;
    cyc();
    @(negedge clk);
    chk("e_ack", 32'(excp_ack), 32'h1);
    chk("e_noflush", 32'(flush), 32'h0);
    chk("e_to", 32'(stall_timeout), 32'h0);
    cyc();
    excp_req = 1'b0;
    @(negedge clk);
    chk("e_flush", 32'(flush), 32'h1);
    chk("e_new_pc", new_pc, 32'h0000_0300);
    cyc();
    stallreq_ex = 1'b0;
    @(negedge clk);
    chk("e_to_after", 32'(stall_timeout), 32'h0);

    // reset while pending
    cyc();
    stallreq_mem = 1'b1;
    excp_req = 1'b1;
    excp_vec = 32'h0000_0444;
    cyc();
    @(negedge clk);
    chk("f_ack", 32'(excp_ack), 32'h1);
    cyc();
    excp_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("f_rst_stall", 32'(stall), 32'h0);
    cyc();
    rst = 1'b0;
    stallreq_mem = 1'b0;
    @(negedge clk);
    chk("f_ack0", 32'(excp_ack), 32'h0);
    chk("f_flush0", 32'(flush), 32'h0);
    chk("f_pc0", new_pc, 32'h0);
    cyc();
    @(negedge clk);
    chk("f_noflush", 32'(flush), 32'h0);
    repeat (3) cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
